// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling and majority vote.
// Received bytes are buffered in a show-ahead FIFO.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  input  logic                          rd,
  input  logic                          err_clr,
  output logic                          rx_vld,
  output logic [7:0]                    rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   rx_cnt,
  output logic                          frm_err,
  output logic                          ovf
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t            state;
  state_t            nxt;
  logic              s1;
  logic              rxs;
  logic [DW-1:0]     div_cnt;
  logic              tick;
  logic [3:0]        sc;
  logic              v7;
  logic              v8;
  logic              vote;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              push_req;
  logic              frm_set;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              full;
  logic              pop;
  logic              do_push;
  logic              ovf_set;

  // two-flop synchroniser on the serial line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rxd;
      rxs <= s1;
    end
  end

  // oversample divider, parked at 0 in IDLE to align on the start edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      div_cnt <= '0;
    else if (state == IDLE)
      div_cnt <= '0;
    else if (div_cnt == DW'(DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign vote = (v7 & v8) | (v7 & rxs) | (v8 & rxs);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  // FSM next state, push and framing-error strobes
  always_comb begin
    nxt      = state;
    push_req = 1'b0;
    frm_set  = 1'b0;
    unique case (state)
      IDLE: if (!rxs) nxt = START;
      START: begin
        if (tick && sc == 4'd9 && vote)
          nxt = IDLE;
        else if (tick && sc == 4'd15)
          nxt = DATA;
      end
      DATA: begin
        if (tick && sc == 4'd15 && bit_idx == 3'd7)
          nxt = STOP;
      end
      STOP: begin
        if (tick && sc == 4'd9) begin
          if (vote) begin
            push_req = 1'b1;
            nxt      = IDLE;
          end else begin
            frm_set  = 1'b1;
            nxt      = BRK;
          end
        end
      end
      BRK: if (rxs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // bit-phase counter, vote samples and LSB-first shifter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sc      <= '0;
      v7      <= 1'b1;
      v8      <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == IDLE) begin
      sc      <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      sc <= sc + 1'b1;
      if (sc == 4'd7) v7 <= rxs;
      if (sc == 4'd8) v8 <= rxs;
      if (state == DATA && sc == 4'd9)
        shreg <= {vote, shreg[7:1]};
      if (state == DATA && sc == 4'd15)
        bit_idx <= bit_idx + 1'b1;
    end
  end

  assign full    = rx_cnt == CW'(FIFO_DEPTH);
  assign pop     = rd && rx_vld;
  assign do_push = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  // FIFO storage, no reset needed since reads are gated by rx_vld
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr   <= '0;
      rptr   <= '0;
      rx_cnt <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (do_push && !pop)
        rx_cnt <= rx_cnt + 1'b1;
      else if (pop && !do_push)
        rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // sticky flags; a new event wins over a clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frm_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      frm_err <= frm_set | (frm_err & ~err_clr);
      ovf     <= ovf_set | (ovf & ~err_clr);
    end
  end

  assign rx_vld  = rx_cnt != '0;
  assign rx_data = rx_vld ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at DIV=4 (64 clk per bit).
// Byte-level queue model predicts FIFO contents and flags.
module tb_uart_rx_fifo;

  localparam int BIT = 64;
  localparam int PUSH_K = 618;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic       rd;
  logic       err_clr;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic [3:0] rx_cnt;
  logic       frm_err;
  logic       ovf;

  int tests;
  int fails;
  logic [7:0] q[$];

  logic       vld_pre;
  logic       vld_at;
  logic [3:0] cnt_at;
  logic [7:0] data_at;

  uart_rx_fifo #(
    .CLK_FREQ(64),
    .BAUD(1),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rxd(rxd),
    .rd(rd),
    .err_clr(err_clr),
    .rx_vld(rx_vld),
    .rx_data(rx_data),
    .rx_cnt(rx_cnt),
    .frm_err(frm_err),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int ncyc, input logic rd_push);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      rxd = bits[k / BIT];
      if (rd_push) rd = (k == PUSH_K);
      @(posedge clk);
      #1;
      if (k == PUSH_K - 1) vld_pre = rx_vld;
      if (k == PUSH_K) begin
        vld_at  = rx_vld;
        cnt_at  = rx_cnt;
        data_at = rx_data;
      end
    end
    rd = 1'b0;
  endtask

  task automatic do_pop(output logic [7:0] d, output logic v);
    v  = rx_vld;
    d  = rx_data;
    rd = 1'b1;
    cycles(1);
    rd = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cycles(3);
    tests++;
    if ({rx_vld, rx_data, rx_cnt, frm_err, ovf} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs got vld=%b data=%h cnt=%0d fe=%b ovf=%b want all 0",
               rx_vld, rx_data, rx_cnt, frm_err, ovf);
    end
    rstn = 1'b1;
    cycles(5);
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic v;
    send_frame(8'hA5, 1'b1, 10 * BIT, 1'b0);
    tests++;
    if (vld_pre !== 1'b0 || vld_at !== 1'b1) begin
      fails++;
      $display("FAIL single_timing got pre=%b at=%b want 0 1", vld_pre, vld_at);
    end
    tests++;
    if (data_at !== 8'hA5 || cnt_at !== 4'd1) begin
      fails++;
      $display("FAIL single_data got %h cnt %0d want a5 cnt 1", data_at, cnt_at);
    end
    do_pop(d, v);
    tests++;
    if (rx_vld !== 1'b0 || rx_cnt !== 4'd0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL single_pop got vld=%b cnt=%0d data=%h want 0 0 00",
               rx_vld, rx_cnt, rx_data);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic v;
    rxd = 1'b0;
    cycles(12);
    rxd = 1'b1;
    cycles(3 * BIT);
    tests++;
    if (rx_cnt !== 4'd0 || frm_err !== 1'b0) begin
      fails++;
      $display("FAIL glitch got cnt=%0d fe=%b want 0 0", rx_cnt, frm_err);
    end
    do_pop(d, v);
    tests++;
    if (rx_cnt !== 4'd0 || rx_vld !== 1'b0) begin
      fails++;
      $display("FAIL empty_rd got cnt=%0d vld=%b want 0 0", rx_cnt, rx_vld);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    logic v;
    send_frame(8'h3C, 1'b0, 10 * BIT, 1'b0);
    rxd = 1'b0;
    cycles(5 * BIT);
    tests++;
    if (frm_err !== 1'b1 || rx_cnt !== 4'd0) begin
      fails++;
      $display("FAIL frame_err got fe=%b cnt=%0d want 1 0", frm_err, rx_cnt);
    end
    rxd = 1'b1;
    cycles(BIT);
    send_frame(8'h11, 1'b1, 10 * BIT, 1'b0);
    tests++;
    if (rx_data !== 8'h11 || rx_cnt !== 4'd1 || frm_err !== 1'b1) begin
      fails++;
      $display("FAIL after_brk got data=%h cnt=%0d fe=%b want 11 1 1",
               rx_data, rx_cnt, frm_err);
    end
    clr_err();
    tests++;
    if (frm_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr got fe=%b want 0", frm_err);
    end
    do_pop(d, v);
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] e;
    logic v;
    logic exp_ovf;
    exp_ovf = 1'b0;
    q.delete();
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 10 * BIT, 1'b0);
      if (q.size() < 8) q.push_back(8'(i));
      else exp_ovf = 1'b1;
    end
    tests++;
    if (rx_cnt !== 4'(q.size()) || ovf !== exp_ovf) begin
      fails++;
      $display("FAIL ovf_fill got cnt=%0d ovf=%b want %0d %b",
               rx_cnt, ovf, q.size(), exp_ovf);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      do_pop(d, v);
      tests++;
      if (v !== 1'b1 || d !== e) begin
        fails++;
        $display("FAIL ovf_pop got v=%b d=%h want 1 %h", v, d, e);
      end
    end
    tests++;
    if (rx_vld !== 1'b0 || rx_cnt !== 4'd0) begin
      fails++;
      $display("FAIL ovf_drop got vld=%b cnt=%0d want 0 0", rx_vld, rx_cnt);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] b;
    logic v;
    clr_err();
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr got %b want 0", ovf);
    end
    q.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 10 * BIT, 1'b0);
      q.push_back(b);
    end
    send_frame(8'h55, 1'b1, 10 * BIT, 1'b1);
    void'(q.pop_front());
    q.push_back(8'h55);
    tests++;
    if (cnt_at !== 4'd8 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL full_pushpop got cnt=%0d ovf=%b want 8 0", cnt_at, ovf);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      do_pop(d, v);
      tests++;
      if (v !== 1'b1 || d !== e) begin
        fails++;
        $display("FAIL full_pop got v=%b d=%h want 1 %h", v, d, e);
      end
    end
    tests++;
    if (d !== 8'h55) begin
      fails++;
      $display("FAIL full_last got %h want 55", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    logic v;
    for (int i = 0; i < 2; i++)
      send_frame(8'($urandom), 1'b1, 10 * BIT, 1'b0);
    send_frame(8'h77, 1'b1, 5 * BIT, 1'b0);
    rxd = 1'b1;
    rstn = 1'b0;
    #1;
    tests++;
    if ({rx_vld, rx_data, rx_cnt, frm_err, ovf} !== 15'd0) begin
      fails++;
      $display("FAIL mid_reset got vld=%b data=%h cnt=%0d fe=%b ovf=%b want all 0",
               rx_vld, rx_data, rx_cnt, frm_err, ovf);
    end
    q.delete();
    cycles(3);
    rstn = 1'b1;
    cycles(BIT);
    send_frame(8'h42, 1'b1, 10 * BIT, 1'b0);
    tests++;
    if (rx_cnt !== 4'd1 || rx_data !== 8'h42) begin
      fails++;
      $display("FAIL post_reset got cnt=%0d data=%h want 1 42", rx_cnt, rx_data);
    end
    do_pop(d, v);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] b;
    logic v;
    int np;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 10 * BIT, 1'b0);
      q.push_back(b);
      tests++;
      if (rx_cnt !== 4'(q.size())) begin
        fails++;
        $display("FAIL rand_cnt got %0d want %0d", rx_cnt, q.size());
      end
      np = $urandom_range(0, 2);
      for (int j = 0; j < np && q.size() > 0; j++) begin
        e = q.pop_front();
        do_pop(d, v);
        tests++;
        if (v !== 1'b1 || d !== e) begin
          fails++;
          $display("FAIL rand_pop got v=%b d=%h want 1 %h", v, d, e);
        end
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      do_pop(d, v);
      tests++;
      if (v !== 1'b1 || d !== e) begin
        fails++;
        $display("FAIL rand_drain got v=%b d=%h want 1 %h", v, d, e);
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rxd     = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    rstn    = 1'b0;
    vld_pre = 1'b0;
    vld_at  = 1'b0;
    cnt_at  = '0;
    data_at = '0;
    #1;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front-end for the debug/IO unit (PDU).
- Synchronises `rxd` and recovers 8N1 frames with 16x oversampling and 3-sample majority voting.
- Buffers received bytes in a small show-ahead FIFO.
- Its outputs drive the PDU's IO read ports 8 (`rx_data`) and 9 (`rx_vld`); the PDU issues `rd` to pop a byte after the CPU has read it.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 115200: line baud rate.
- FIFO_DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- DIV, CLK_FREQ/(BAUD*16) (integer, truncated): clocks per oversample tick; must be at least 2. Derived, not overridden directly.

Ports:
- clk, input, 1: system clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- rxd, input, 1: serial line; idles high.
- rd, input, 1: pop request for the head byte; one pop per cycle it is high.
- err_clr, input, 1: clears the sticky error flags.
- rx_vld, output, 1: FIFO non-empty.
- rx_data, output, 8: head byte of the FIFO; valid while `rx_vld`=1, otherwise 0.
- rx_cnt, output, clog2(FIFO_DEPTH)+1: number of bytes currently buffered.
- frm_err, output, 1: sticky; a stop bit was sampled as 0.
- ovf, output, 1: sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (`rstn`=0, asynchronous):
  - Synchroniser flops reset to 1, the tick divider to 0, the FSM to IDLE, and both FIFO pointers to 0.
  - Outputs: `rx_vld`=0, `rx_data`=0, `rx_cnt`=0, `frm_err`=0, `ovf`=0.
  - A reset mid-frame discards the partial byte. No push occurs on release.
- Synchroniser: two flops on `rxd` produce `rxs`. All decisions use `rxs`, giving 2 cycles of latency from `rxd`.
- Tick generator:
  - Counter runs 0..DIV-1; `tick`=1 for one cycle when it equals DIV-1.
  - The counter free-runs in every state except IDLE. In IDLE it is held at 0, so phase is aligned to the start edge.
- Within-bit tick counter `sc` (0..15) advances on each `tick`.
  - Samples are taken at sc=7, 8 and 9; the bit value is the majority of the three.
  - A bit ends on the tick where sc=15.
- FSM states: IDLE, START, DATA, STOP, BRK.
  - IDLE: when `rxs`=0, go to START with sc=0.
  - START: at the sc=9 vote, a majority of 1 is a false start and returns to IDLE. Otherwise stay until sc=15, then go to DATA with bit index 0.
  - DATA: shift in 8 bits, LSB first, each decided at sc=9. After bit 7 reaches sc=15, go to STOP.
  - STOP, vote = 1: push the byte into the FIFO and go to IDLE immediately at sc=9, without waiting to sc=15. This allows back-to-back frames.
  - STOP, vote = 0: set `frm_err`, do not push, and go to BRK.
  - BRK: stay until `rxs`=1, then go to IDLE. A held-low line therefore never produces bytes.
- FIFO (show-ahead):
  - `rx_data` = mem[rptr] combinationally when non-empty.
  - A push takes effect the cycle after the STOP decision, so `rx_vld` rises that cycle.
  - Pop when `rd`=1 and `rx_cnt`>0. `rd` while empty is ignored; no underflow and no flag.
  - Push while full, with no pop in the same cycle: the byte is dropped and `ovf` is set.
  - Push and pop in the same cycle:
    - Both complete and `rx_cnt` is unchanged.
    - This includes the full case: no drop and no `ovf`.
    - If `rx_cnt`=0, the push completes and the `rd` is ignored, so the pop does not apply.
  - Pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally. `rx_cnt` saturates at FIFO_DEPTH.
- Sticky flags: `err_clr` clears `frm_err` and `ovf`. A new error event in the same cycle takes precedence, so the flag stays set.

Test Plan (CLK_FREQ=64, BAUD=1, giving DIV=4 and 64 clk per bit):
- Send 0xA5 with a valid stop bit → exactly one cycle after the stop-bit sc=9 vote, `rx_vld`=1, `rx_data`=0xA5, `rx_cnt`=1. Then pulse `rd` for 1 cycle → `rx_vld`=0, `rx_cnt`=0.
- Drive a 12-clk low glitch on the idle line → FSM returns to IDLE, no push, `rx_cnt`=0, `frm_err`=0.
- Send 0x3C with stop bit 0, then hold the line low for 5 bit-times → `frm_err`=1, `rx_cnt`=0, no further bytes. Release the line, send 0x11 → `rx_data`=0x11. Pulse `err_clr` → `frm_err`=0.
- Send bytes 0x01..0x09 back-to-back with no reads → `rx_cnt`=8, `ovf`=1. Eight pops return 0x01..0x08 in order; 0x09 is absent.
- With the FIFO full, assert `rd` in the cycle 0x55 is pushed → `rx_cnt` stays 8, `ovf`=0, and 0x55 is returned as the 8th subsequent pop.
- Assert `rstn`=0 mid-way through DATA of 0x77 with 2 bytes buffered → all outputs 0 immediately. After release, the next frame 0x42 is received alone with `rx_cnt`=1.
